id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 152 +++++++++++++++
 tb/tb_id_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: splits the fetched word, reads the 32-entry register file with write-back bypass, registers the operands.
// Latency 1 cycle; outputs hold while ex_ready is low and if_ready drops, flush discards, a HALT_OP capture stops intake until reset.
module id_stage #(
    parameter int         XLEN    = 32,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] npc_if,
    input  logic [31:0]     ir_if,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] d,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] npc_id,
    output logic [31:0]     ir_id,
    output logic            hlt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_run;

    logic            r_id_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_npc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_regs [32];

    logic [5:0]      w_op;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm;
    logic            w_wb_hit;
    logic            w_capture;
    logic [XLEN-1:0] w_rd_val;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_op  = ir_if[31:26];
    assign w_rd  = ir_if[25:21];
    assign w_rs1 = ir_if[20:16];
    assign w_rs2 = ir_if[15:11];
    assign w_imm = {{(XLEN-16){ir_if[15]}}, ir_if[15:0]};

    assign w_wb_hit  = wb_en && (wb_rd != 5'd0);
    assign if_ready  = rst_n && (!r_id_valid || ex_ready) && w_run && !flush;
    assign w_capture = if_valid && if_ready;

    // A write landing this cycle is forwarded so a dependent read never sees the stale value.
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                       (w_wb_hit && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                       (w_wb_hit && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
    assign w_rd_val  = (w_rd == 5'd0) ? '0 :
                       (w_wb_hit && wb_rd == w_rd) ? wb_data : r_regs[w_rd];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            S_RUN: begin
                w_run = 1'b1;
                if (w_capture && w_op == HALT_OP) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_hit) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Flush wins over both capture and hold; capture cannot coincide with it since if_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (w_capture) begin
            r_id_valid <= 1'b1;
        end else if (ex_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_imm <= '0;
            r_npc <= '0;
            r_ir  <= '0;
        end else if (w_capture) begin
            r_a   <= w_rs1_val;
            r_b   <= w_rs2_val;
            r_d   <= w_rd_val;
            r_imm <= w_imm;
            r_npc <= npc_if;
            r_ir  <= ir_if;
        end
    end

    assign id_valid = r_id_valid;
    assign a        = r_a;
    assign b        = r_b;
    assign d        = r_d;
    assign imm      = r_imm;
    assign npc_id   = r_npc;
    assign ir_id    = r_ir;
    assign hlt      = (r_state == S_HALT);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage at XLEN=64: directed vector table for the listed scenarios, then randomized traffic against a reference model.
module tb_id_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n, if_valid, if_ready, flush, wb_en, ex_ready;
    logic [XLEN-1:0] npc_if, wb_data;
    logic [31:0]     ir_if;
    logic [4:0]      wb_rd;
    logic            id_valid, hlt;
    logic [XLEN-1:0] a, b, d, imm, npc_id;
    logic [31:0]     ir_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN), .HALT_OP(6'h3F)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .npc_if(npc_if), .ir_if(ir_if), .flush(flush), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
        .id_valid(id_valid), .a(a), .b(b), .d(d), .imm(imm),
        .npc_id(npc_id), .ir_id(ir_id), .hlt(hlt)
    );

    // Reference model: architectural register file plus the decoded output bundle.
    logic [XLEN-1:0] m_regs [32];
    logic            m_valid, m_halt, m_rdy;
    logic [XLEN-1:0] m_a, m_b, m_d, m_imm, m_npc;
    logic [31:0]     m_ir;
    logic            s_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    task automatic model_edge();
        logic signed [15:0] s16;
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_valid = 0; m_halt = 0;
            m_a = 0; m_b = 0; m_d = 0; m_imm = 0; m_npc = 0; m_ir = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
            end else if (if_valid && m_rdy) begin
                s16     = ir_if[15:0];
                m_a     = model_read(ir_if[20:16]);
                m_b     = model_read(ir_if[15:11]);
                m_d     = model_read(ir_if[25:21]);
                m_imm   = XLEN'(s16);
                m_npc   = npc_if;
                m_ir    = ir_if;
                m_valid = 1;
                if (ir_if[31:26] == 6'h3F) m_halt = 1;
            end else if (ex_ready) begin
                m_valid = 0;
            end
            if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        end
    endtask

    // Called mid-cycle with inputs already driven; returns mid-cycle after the edge.
    task automatic do_cycle();
        #1;
        m_rdy = rst_n && (!m_valid || ex_ready) && !m_halt && !flush;
        s_rdy = if_ready;
        chk("if_ready", s_rdy, m_rdy);
        model_edge();
        @(posedge clk);
        #1;
        chk("id_valid", id_valid, m_valid);
        chk("hlt", hlt, m_halt);
        chk("a", a, m_a);
        chk("b", b, m_b);
        chk("d", d, m_d);
        chk("imm", imm, m_imm);
        chk("npc_id", npc_id, m_npc);
        chk("ir_id", ir_id, m_ir);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [10:0] lo);
        return {op, rd, rs1, rs2, lo};
    endfunction

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] ir;
        logic        fl;
        logic        we;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        exr;
        logic        e_rdy;
        logic        e_vld;
        logic [63:0] e_a;
        logic [63:0] e_b;
        logic [63:0] e_imm;
        logic        e_hlt;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // rst vld ir fl we wrd wd exr | rdy vld a b imm hlt
        tbl[0]  = '{0, 1, mk(1, 1, 3, 0, 0),       0, 1, 5'd4, 64'h44,   1, 0, 0, 0,       0,       0,                      0};
        tbl[1]  = '{1, 0, mk(0, 0, 0, 0, 0),       0, 1, 5'd3, 64'h1234, 1, 1, 0, 0,       0,       0,                      0};
        tbl[2]  = '{1, 1, mk(1, 1, 3, 0, 0),       0, 0, 5'd0, 64'h0,    1, 1, 1, 64'h1234, 0,       0,                      0};
        tbl[3]  = '{1, 1, mk(1, 2, 0, 5, 1),       0, 1, 5'd5, 64'hCAFE, 1, 1, 1, 0,       64'hCAFE, 64'h2801,              0};
        tbl[4]  = '{1, 1, mk(2, 2, 0, 16, 1),      0, 1, 5'd0, 64'hFFFF, 1, 1, 1, 0,       0,       64'hFFFF_FFFF_FFFF_8001, 0};
        tbl[5]  = '{1, 1, mk(1, 1, 3, 15, 11'h7FF),0, 0, 5'd0, 64'h0,    1, 1, 1, 64'h1234, 0,       64'h7FFF,              0};
        tbl[6]  = '{1, 1, mk(1, 1, 5, 0, 0),       0, 0, 5'd0, 64'h0,    0, 0, 1, 64'h1234, 0,       64'h7FFF,              0};
        tbl[7]  = '{1, 1, mk(1, 1, 5, 0, 0),       0, 0, 5'd0, 64'h0,    0, 0, 1, 64'h1234, 0,       64'h7FFF,              0};
        tbl[8]  = '{1, 1, mk(1, 1, 5, 0, 0),       0, 0, 5'd0, 64'h0,    0, 0, 1, 64'h1234, 0,       64'h7FFF,              0};
        tbl[9]  = '{1, 1, mk(1, 0, 5, 3, 0),       0, 0, 5'd0, 64'h0,    1, 1, 1, 64'hCAFE, 64'h1234, 64'h1800,              0};
        tbl[10] = '{1, 1, mk(1, 0, 3, 3, 0),       1, 1, 5'd7, 64'h77,   1, 0, 0, 64'hCAFE, 64'h1234, 64'h1800,              0};
        tbl[11] = '{1, 1, mk(1, 1, 7, 0, 0),       0, 0, 5'd0, 64'h0,    1, 1, 1, 64'h77,   0,       0,                      0};
        tbl[12] = '{1, 0, mk(0, 0, 0, 0, 0),       0, 0, 5'd0, 64'h0,    1, 1, 0, 64'h77,   0,       0,                      0};
        tbl[13] = '{1, 1, mk(6'h3F, 0, 5, 0, 0),   0, 0, 5'd0, 64'h0,    1, 1, 1, 64'hCAFE, 0,       0,                      1};
        tbl[14] = '{1, 1, mk(1, 1, 3, 0, 0),       1, 0, 5'd0, 64'h0,    0, 0, 0, 64'hCAFE, 0,       0,                      1};
        tbl[15] = '{1, 1, mk(1, 1, 3, 0, 0),       0, 0, 5'd0, 64'h0,    1, 0, 0, 64'hCAFE, 0,       0,                      1};
        tbl[16] = '{0, 1, mk(1, 1, 3, 0, 0),       0, 1, 5'd9, 64'h99,   1, 0, 0, 0,       0,       0,                      0};
        tbl[17] = '{1, 0, mk(0, 0, 0, 0, 0),       0, 0, 5'd0, 64'h0,    1, 1, 0, 0,       0,       0,                      0};
        tbl[18] = '{1, 1, mk(1, 2, 3, 9, 0),       0, 0, 5'd0, 64'h0,    1, 1, 1, 0,       0,       64'h4800,              0};

        rst_n = 0; if_valid = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        ex_ready = 1; npc_if = 0; ir_if = 0;
        m_valid = 0; m_halt = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            rst_n    = tbl[i].rst;
            if_valid = tbl[i].vld;
            ir_if    = tbl[i].ir;
            npc_if   = 64'h1000 + 64'(i * 4);
            flush    = tbl[i].fl;
            wb_en    = tbl[i].we;
            wb_rd    = tbl[i].wrd;
            wb_data  = tbl[i].wd;
            ex_ready = tbl[i].exr;
            do_cycle();
            chk($sformatf("vec%0d if_ready", i), s_rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d id_valid", i), id_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d a", i), a, tbl[i].e_a);
            chk($sformatf("vec%0d b", i), b, tbl[i].e_b);
            chk($sformatf("vec%0d imm", i), imm, tbl[i].e_imm);
            chk($sformatf("vec%0d hlt", i), hlt, tbl[i].e_hlt);
        end

        // Hold must freeze the whole output bundle, not just the fields in the table.
        if_valid = 1; ir_if = mk(1, 3, 3, 5, 0); npc_if = 64'hABCD; ex_ready = 1;
        flush = 0; wb_en = 0; rst_n = 1;
        do_cycle();
        ex_ready = 0; ir_if = mk(2, 4, 4, 4, 4); npc_if = 64'h5555;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("hold npc_id", npc_id, 64'hABCD);
            chk("hold ir_id", ir_id, mk(1, 3, 3, 5, 0));
        end

        for (int n = 0; n < 1500; n++) begin
            rst_n    = ($urandom_range(0, 99) >= 3);
            if_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 31));
            wb_data  = {$urandom, $urandom};
            npc_if   = {$urandom, $urandom};
            ir_if    = $urandom;
            if ($urandom_range(0, 7) == 0) ir_if[20:16] = wb_rd;
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
